// File: rtl/matmul_pkg.sv
// Shared matrix-multiply definitions: dimensions, element type, C-matrix address map.
// Also carries the result-reader beat struct and FSM state type.
package matmul_pkg;
  localparam int N  = 8;
  localparam int DW = 19;
  localparam int AW = 6;
  localparam int RW = $clog2(N);

  typedef logic signed [DW-1:0] c_elem_t;
  typedef logic [RW-1:0]        idx_t;

  typedef struct packed {
    c_elem_t data;
    idx_t    row;
    idx_t    col;
    logic    last;
  } c_beat_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} rd_state_t;

  // C is stored column-major in the output RAM
  function automatic logic [AW-1:0] c_addr(input idx_t r, input idx_t c);
    return AW'(int'(c) * N + int'(r));
  endfunction
endpackage

// File: rtl/c_result_reader_if.sv
// RAM read port and output stream of the C result reader.
// master = reader side, slave = RAM/consumer side.
interface c_result_reader_if;
  import matmul_pkg::*;

  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  c_elem_t         mem_rdata;
  logic            out_valid;
  logic            out_ready;
  c_elem_t         out_data;
  idx_t            out_row;
  idx_t            out_col;
  logic            out_last;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_row, out_col, out_last,
    input  mem_rdata, out_ready
  );
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_row, out_col, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/c_reader_fifo2.sv
// Two-entry FIFO of result beats; head is registered so outputs hold while stalled.
module c_reader_fifo2
  import matmul_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  c_beat_t    in_beat,
  input  logic       pop,
  output c_beat_t    head,
  output logic       valid,
  output logic [1:0] count
);
  c_beat_t slot1;

  assign valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_beat;
          else               slot1 <= in_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the older entry moves up first
          if (count == 2'd2) begin
            head  <= slot1;
            slot1 <= in_beat;
          end else begin
            head  <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/c_result_reader.sv
// Drains the NxN C matrix from the output RAM and streams it row-major with tags.
// Optional C_READER_SAT16_EN clamps beats to 16-bit signed range and flags it in sat_seen.
module c_result_reader
  import matmul_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic sat_seen,
  c_result_reader_if.master bus
);
  rd_state_t  state;
  logic [6:0] issue_cnt;
  logic       inflight;
  idx_t       fl_row, fl_col;
  logic       fl_last;
  logic [1:0] fifo_count;
  logic       fifo_valid;
  logic       pop, room, issue;
  c_beat_t    push_beat, head;

  assign pop   = fifo_valid & bus.out_ready;
  // a read may issue only if its data is guaranteed a slot when it returns
  assign room  = ({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign issue = (state == S_READ) && room;

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = c_addr(issue_cnt[5:3], issue_cnt[2:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= 7'd0;
      inflight  <= 1'b0;
      fl_row    <= '0;
      fl_col    <= '0;
      fl_last   <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (issue) begin
        fl_row    <= issue_cnt[5:3];
        fl_col    <= issue_cnt[2:0];
        fl_last   <= (issue_cnt == 7'd63);
        issue_cnt <= issue_cnt + 7'd1;
      end
      case (state)
        S_IDLE: if (start) begin
          state     <= S_READ;
          busy      <= 1'b1;
          issue_cnt <= 7'd0;
        end
        S_READ:  if (issue && issue_cnt == 7'd63) state <= S_DRAIN;
        S_DRAIN: if (pop && head.last) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
      endcase
    end
  end

`ifdef C_READER_SAT16_EN
  localparam c_elem_t SAT_MAX = 19'sd32767;
  localparam c_elem_t SAT_MIN = -19'sd32768;
  logic clamp_hi, clamp_lo;

  assign clamp_hi = bus.mem_rdata > SAT_MAX;
  assign clamp_lo = bus.mem_rdata < SAT_MIN;

  always_comb begin
    push_beat      = '0;
    push_beat.data = clamp_hi ? SAT_MAX : (clamp_lo ? SAT_MIN : bus.mem_rdata);
    push_beat.row  = fl_row;
    push_beat.col  = fl_col;
    push_beat.last = fl_last;
  end

  always_ff @(posedge clk) begin
    if (reset)                          sat_seen <= 1'b0;
    else if (state == S_IDLE && start)  sat_seen <= 1'b0;
    else if (inflight && (clamp_hi || clamp_lo)) sat_seen <= 1'b1;
  end
`else
  always_comb begin
    push_beat      = '0;
    push_beat.data = bus.mem_rdata;
    push_beat.row  = fl_row;
    push_beat.col  = fl_col;
    push_beat.last = fl_last;
  end

  assign sat_seen = 1'b0;
`endif

  c_reader_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (inflight),
    .in_beat (push_beat),
    .pop     (pop),
    .head    (head),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = head.data;
  assign bus.out_row   = head.row;
  assign bus.out_col   = head.col;
  assign bus.out_last  = head.last;
endmodule

// File: tb/tb_c_result_reader.sv
// Directed bench for c_result_reader: RAM model, stall patterns, reset/restart, saturation.
module tb_c_result_reader;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, sat_seen;
  int   passes = 0, total = 0;
  int   cval [8][8];
  c_elem_t mem [64];

  c_result_reader_if bus();

  c_result_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sat_seen (sat_seen),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int expv(input int r, input int c);
    int v;
    v = cval[r][c];
`ifdef C_READER_SAT16_EN
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v;
  endfunction

  task automatic load();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[c*8 + r] = c_elem_t'(cval[r][c]);
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: ready high; mode 1: patterned ready. stop_at/restart_at < 0 disable.
  task automatic drain(input int mode, input int stop_at, input int restart_at,
                       output int beats, output int dones);
    int cyc = 0, first_cyc = -1, last_cyc = -1, pi = 0;
    logic [15:0] pat = 16'h96C9;
    logic held = 1'b0, restarted = 1'b0;
    c_elem_t hd; idx_t hr, hc; logic hl;
    beats = 0; dones = 0;
    while (cyc < 2000) begin
      @(negedge clk); cyc++;
      if (held) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, hd);
        chk("stall_row", bus.out_row, hr);
        chk("stall_col", bus.out_col, hc);
        chk("stall_last", bus.out_last, hl);
        held = 1'b0;
      end
      if (done) begin
        dones++;
        chk("done_after_last", cyc - last_cyc, 1);
        chk("beat_count", beats, 64);
        if (mode == 0) chk("back_to_back", last_cyc - first_cyc, 63);
        return;
      end
      start = (restart_at >= 0 && beats == restart_at && !restarted);
      if (start) restarted = 1'b1;
      bus.out_ready = (mode == 0) ? 1'b1 : pat[pi % 16];
      pi++;
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_data", bus.out_data, expv(beats / 8, beats % 8));
        chk("beat_row", bus.out_row, beats / 8);
        chk("beat_col", bus.out_col, beats % 8);
        chk("beat_last", bus.out_last, beats == 63);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
        if (beats == stop_at) return;
      end else if (bus.out_valid) begin
        held = 1'b1;
        hd = bus.out_data; hr = bus.out_row; hc = bus.out_col; hl = bus.out_last;
      end
    end
    chk("drain_timeout", dones, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_row"}, bus.out_row, 0);
    chk({tag, "_col"}, bus.out_col, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_sat"}, sat_seen, 0);
  endtask

  initial begin
    int beats, dones, reads, extra_done, extra_busy;
    reset = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cval[r][c] = r*8 + c;
    load();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1: full-rate drain with latency checks
    bus.out_ready = 1'b1;
    start_pulse();
    chk("t1_busy", busy, 1);
    chk("t1_rd_en_p1", bus.mem_rd_en, 1);
    chk("t1_addr_p1", bus.mem_addr, 0);
    chk("t1_valid_p1", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_valid_p2", bus.out_valid, 0);
    chk("t1_addr_p2", bus.mem_addr, 8);
    drain(0, -1, -1, beats, dones);
    chk("t1_dones", dones, 1);
    @(negedge clk);
    chk("t1_done_width", done, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_sat", sat_seen, 0);

    // 2: patterned backpressure
    start_pulse();
    drain(1, -1, -1, beats, dones);
    chk("t2_dones", dones, 1);

    // 3: consumer stalled 20 cycles after start
    bus.out_ready = 1'b0;
    start_pulse();
    reads = int'(bus.mem_rd_en);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      reads += int'(bus.mem_rd_en);
      if (i == 2) chk("t3_valid_early", bus.out_valid, 1);
    end
    chk("t3_reads", reads, 2);
    chk("t3_valid_held", bus.out_valid, 1);
    chk("t3_data_held", bus.out_data, 0);
    chk("t3_busy", busy, 1);
    drain(0, -1, -1, beats, dones);
    chk("t3_dones", dones, 1);

    // 4: reset mid-drain, then a clean run
    bus.out_ready = 1'b1;
    start_pulse();
    drain(0, 30, -1, beats, dones);
    chk("t4_beats_before_reset", beats, 30);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t4");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_no_stale_valid", bus.out_valid, 0);
    start_pulse();
    drain(0, -1, -1, beats, dones);
    chk("t4_dones", dones, 1);

    // 5: second start mid-drain is ignored
    start_pulse();
    drain(0, -1, 10, beats, dones);
    start = 1'b0;
    chk("t5_dones", dones, 1);
    extra_done = 0; extra_busy = 0;
    repeat (6) begin
      @(negedge clk);
      extra_done += int'(done);
      extra_busy += int'(busy);
    end
    chk("t5_no_second_done", extra_done, 0);
    chk("t5_no_second_run", extra_busy, 0);

    // 6: values outside 16-bit range
    cval[2][3] = 40000;
    cval[5][5] = -70000;
    load();
    start_pulse();
    drain(0, -1, -1, beats, dones);
    chk("t6_dones", dones, 1);
`ifdef C_READER_SAT16_EN
    chk("t6_sat_seen", sat_seen, 1);
`else
    chk("t6_sat_seen", sat_seen, 0);
`endif
    cval[2][3] = 19;
    cval[5][5] = 45;
    load();
    start_pulse();
    chk("t6_sat_cleared", sat_seen, 0);
    drain(0, -1, -1, beats, dones);
    chk("t6_clean_dones", dones, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
